inverse_sub_bytes_serial: RTL and testbench
===========================================

# inverse_sub_bytes_serial

Serial InvSubBytes stage (optionally fused with InvShiftRows) for the AES decryption datapath, feeding the inverse mix-columns stage. Accepts one 128-bit state and substitutes one byte per clock through a single shared inverse S-box. Produces the full result after 16 cycles, trading throughput for area. Uses the same column-major state packing as the rest of the datapath.

## Interface
- `word_size`, 8, byte width; fixed at 8, since the inverse S-box is 8-bit.
- `array_size`, 16, bytes per state.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  start request; sampled only in IDLE.
- `state`  in  128  input state. Byte n = `state[(15-n)*8 +: 8]`, holding row n%4, column n/4.
- `state_out`  out  128  result state, same packing; holds its value until the next completion.
- `busy`  out  1  high while a state is being processed.
- `done`  out  1  one-cycle pulse, coincident with `state_out` update.

## Operation
- FSM has two states, IDLE and BUSY; a 4-bit byte counter `cnt`; a 128-bit working buffer `buf`.
- IDLE, `enable`=1 at a rising edge (the capture edge):
  - `buf` <= `state` (permuted, see Configuration).
  - `cnt` <= 0, `busy` <= 1, go to BUSY.
- IDLE, `enable`=0: hold.
- BUSY, each edge:
  - byte `cnt` of `buf` <= InvSbox(byte `cnt` of `buf`), per the FIPS-197 inverse S-box table.
  - `cnt` <= `cnt`+1.
- BUSY with `cnt`=15:
  - `state_out` <= `buf`, with byte 15 already substituted.
  - `done` <= 1, `busy` <= 0, `cnt` wraps to 0, go to IDLE.
- `enable` is ignored while BUSY. `state` may change freely after the capture edge.
- The inverse S-box is combinational: a 256-entry case/ROM selected by the byte at `cnt`.
- `done` is cleared on every edge where the completion condition is not met.

## Timing
- Reset values: `state_out`=0, `busy`=0, `done`=0, `cnt`=0, `buf`=0, FSM=IDLE.
- Latency: capture edge E0. Substitution edges are E1..E16. `state_out` is valid and `done`=1 after E16.
- Throughput: one state per 17 cycles.
  - The earliest next capture is E17: `enable` sampled high at E17 while in IDLE.
  - An `enable` held high through E16 is not accepted at E16.
- `busy` is high from after E0 through E16, and low after E16.
- Reset asserted mid-operation aborts immediately and asynchronously:
  - all outputs and state return to their reset values;
  - the partial result is discarded; no `done` is produced.
- `rst` and `enable` both high: reset wins.
- Counter wrap from 15 to 0 occurs only at completion; `cnt` never exceeds 15.

## Configuration
- Macro: `INV_SHIFT_ROWS_EN`.
- Defined: InvShiftRows is applied at capture. `buf` byte n (row r = n%4, column c = n/4) <= `state` byte 4*((c-r) mod 4)+r, i.e. row r is rotated right by r. No extra latency.
- Undefined: `buf` <= `state` unchanged; the block is pure InvSubBytes and InvShiftRows is done elsewhere.
- Timing, ports and reset behaviour are identical in both builds.

## Test plan
- **All zeros.** Reset, then `state`=0, `enable`=1 for one cycle.
  - Expect `done` exactly 16 cycles after capture and `state_out`=0x5252…52 (16 bytes) in both builds.
  - Expect `busy` high for exactly 16 cycles.
- **Ascending bytes, macro undefined.** `state`=0x000102030405060708090a0b0c0d0e0f.
  - Expect `state_out`=0x52096ad53036a538bf40a39e81f3d7fb.
- **Ascending bytes, `INV_SHIFT_ROWS_EN` defined.** Same input.
  - Expect `state_out`=0x52f3a3383009d79ebf366afb8140a5d5.
- **Enable held high.** `state`=0x6363…63 with `enable` held high continuously.
  - Expect `state_out`=0 and `done` pulses exactly every 17 cycles.
  - Changes to `state` while `busy`=1 must have no effect.
- **Reset mid-operation.** Assert `rst` at cycle 8 of BUSY.
  - Expect `busy`, `done` and `state_out` to be 0 immediately, without waiting for a clock edge.
  - After release and a new start with `state`=0xffff…ff, expect 0x7d7d…7d.
- **Simultaneous `rst` and `enable`.** Expect the block to stay in IDLE with `busy`=0.

Source files
------------

// File: rtl/inverse_sub_bytes_serial.sv
// inverse_sub_bytes_serial: one-byte-per-clock InvSubBytes over a 128-bit state; INV_SHIFT_ROWS_EN fuses InvShiftRows at capture.
module inverse_sub_bytes_serial #(
  parameter int word_size  = 8,
  parameter int array_size = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [word_size*array_size-1:0]  state,
  output logic [word_size*array_size-1:0]  state_out,
  output logic                             busy,
  output logic                             done
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  typedef enum logic {IDLE, BUSY} st_t;
  st_t          st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] buf_q, buf_d, state_out_q, state_out_d, cap;
  logic         busy_q, busy_d, done_q, done_d;
  logic [7:0]   cur, sub;
`ifdef INV_SHIFT_ROWS_EN
  // row r of the captured state is rotated right by r columns
  always_comb begin
    cap = '0;
    for (int n = 0; n < 16; n++)
      cap[(15-n)*8 +: 8] = state[(15-(4*(((n/4)-(n%4))&3)+(n%4)))*8 +: 8];
  end
`else
  always_comb cap = state;
`endif
  always_comb begin
    cur = buf_q[{~cnt_q, 3'b000} +: 8];
    sub = INV_SBOX[{~cur, 3'b000} +: 8];
    st_d = st_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    state_out_d = state_out_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (st_q == IDLE && enable) begin
      buf_d = cap;
      cnt_d = '0;
      busy_d = 1'b1;
      st_d = BUSY;
    end else if (st_q == BUSY) begin
      buf_d[{~cnt_q, 3'b000} +: 8] = sub;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        state_out_d = buf_d;
        done_d = 1'b1;
        busy_d = 1'b0;
        st_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      buf_q <= '0;
      state_out_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      state_out_q <= state_out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign state_out = state_out_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_inverse_sub_bytes_serial.sv
// tb_inverse_sub_bytes_serial: vector table plus corner sequences; expectations come from a GF(2^8)-derived inverse S-box model.
module tb_inverse_sub_bytes_serial;
  logic         clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [127:0] state = '0, state_out;
  logic         busy, done;
  int           n_cmp = 0, n_bad = 0;
  logic [7:0]   inv_tb [256];
  logic [127:0] sb [$];
  typedef struct {logic [127:0] in; logic [127:0] exp; string name;} vec_t;
  vec_t vt [5];

  inverse_sub_bytes_serial dut (
    .clk(clk), .rst(rst), .enable(enable), .state(state),
    .state_out(state_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] fsbox(input logic [7:0] x);
    logic [7:0] v = '0;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] t = s, r;
`ifdef INV_SHIFT_ROWS_EN
    for (int n = 0; n < 16; n++) begin
      int rr = n % 4, c = n / 4;
      t[(15-n)*8 +: 8] = s[(15-(4*((c - rr + 4) % 4) + rr))*8 +: 8];
    end
`endif
    for (int n = 0; n < 16; n++) r[(15-n)*8 +: 8] = inv_tb[t[(15-n)*8 +: 8]];
    return r;
  endfunction

  always @(negedge clk) if (done) begin
    if (sb.size() == 0) chk("unexpected_done", state_out, 'x);
    else chk("result", state_out, sb.pop_front());
  end

  task automatic run_one(input logic [127:0] in, input logic [127:0] exp);
    int cycles = 0, busy_n = 0;
    @(negedge clk);
    state = in;
    enable = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    enable = 1'b0;
    state = {$urandom, $urandom, $urandom, $urandom};
    while (!done && cycles < 40) begin
      busy_n += int'(busy);
      @(negedge clk);
      state = {$urandom, $urandom, $urandom, $urandom};
      cycles++;
    end
    chk("latency", 128'(cycles), 128'd16);
    chk("busy_cycles", 128'(busy_n), 128'd16);
    chk("busy_low_at_done", 128'(busy), 128'd0);
  endtask

  initial begin
    logic [127:0] rv;
    int t = 0, last = 0, dn = 0;
    for (int x = 0; x < 256; x++) inv_tb[fsbox(8'(x))] = 8'(x);
    rv = {$urandom, $urandom, $urandom, $urandom};
    vt[0] = '{128'h0, {16{8'h52}}, "zeros"};
`ifdef INV_SHIFT_ROWS_EN
    vt[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52f3a3383009d79ebf366afb8140a5d5, "ascending"};
`else
    vt[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb, "ascending"};
`endif
    vt[2] = '{{16{8'h63}}, 128'h0, "all63"};
    vt[3] = '{{16{8'hff}}, {16{8'h7d}}, "allff"};
    vt[4] = '{rv, model(rv), "random"};
    @(negedge clk);
    chk("reset_state_out", state_out, 128'h0);
    chk("reset_busy_done", {busy, done}, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_one(vt[i].in, vt[i].exp);
    // enable held high: captures every 17 cycles, state scrambled while busy
    @(negedge clk);
    state = {16{8'h63}};
    enable = 1'b1;
    repeat (3) sb.push_back(128'h0);
    while (dn < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (done) begin
        dn++;
        if (dn > 1) chk("done_period", 128'(t - last), 128'd17);
        last = t;
        state = {16{8'h63}};
        if (dn == 3) enable = 1'b0;
      end else if (busy) state = {$urandom, $urandom, $urandom, $urandom};
    end
    chk("held_done_count", 128'(dn), 128'd3);
    // asynchronous reset in the middle of a run
    @(negedge clk);
    state = {16{8'h11}};
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy_before_rst", 128'(busy), 128'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {state_out, busy, done}, 130'h0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_and_enable_idle", {busy, done}, 2'b00);
    enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 128'(busy), 128'd0);
    run_one({16{8'hff}}, {16{8'h7d}});
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
